fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side pointer/flag controller of the asynchronous FIFO, clocked entirely by the write clock.
//  Produces the Gray-coded write pointer that the read-domain 2-FF synchronizer samples.
//  Consumes the read pointer after it has crossed into the write domain via the same synchronizer type.
//  Generates memory write address/enable, full, almost_full, fill level and a sticky overflow error.
// PARAMETERS
//  ADDR_WIDTH          4   memory address bits; depth = 2**ADDR_WIDTH; must be >= 2
//  ALMOST_FULL_THRESH  12  almost_full asserts when wr_level >= this; legal range 1..2**ADDR_WIDTH
// PORTS
//  clk               in   1             write-domain clock
//  rst_n             in   1             asynchronous, active-low reset
//  wr_en             in   1             write request (data path outside this block)
//  ovf_clr           in   1             clears sticky overflow
//  rd_ptr_gray_sync  in   ADDR_WIDTH+1  read pointer, Gray, already synchronized to clk
//  wr_ptr_gray       out  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchronizer
//  wr_addr           out  ADDR_WIDTH    memory write address = low ADDR_WIDTH bits of binary pointer
//  mem_we            out  1             memory write enable = wr_en & ~full (combinational)
//  full              out  1             registered full flag
//  almost_full       out  1             registered, wr_level >= ALMOST_FULL_THRESH
//  wr_level          out  ADDR_WIDTH+1  registered fill count, 0..2**ADDR_WIDTH
//  overflow          out  1             sticky: wr_en seen while full
// BEHAVIOUR
//  - Reset (async, rst_n=0): binary ptr, wr_ptr_gray, wr_addr, full, almost_full, wr_level, overflow all 0.
//    Reset mid-operation clears immediately; read side must be reset in the same event (system rule).
//  - Pointers: binary wr_bin (ADDR_WIDTH+1 bits) and wr_ptr_gray both registered.
//    wr_bin_next = wr_bin + mem_we; gray_next = wr_bin_next ^ (wr_bin_next >> 1).
//    wr_ptr_gray driven directly from a flop (no combinational logic toward the synchronizer).
//  - Wrap-around: wr_bin wraps 2**(ADDR_WIDTH+1)-1 -> 0 naturally; Gray changes exactly one bit per increment incl. wrap.
//  - Full: full <= (gray_next == {~rd_ptr_gray_sync[MSB:MSB-1], rd_ptr_gray_sync[MSB-2:0]}).
//    Write on edge k that fills the FIFO -> full=1 after edge k (no extra latency).
//    Release: full falls on the first clk edge after rd_ptr_gray_sync shows space (pessimistic by sync lag; never optimistic).
//  - Level: wr_level <= wr_bin_next - gray2bin(rd_ptr_gray_sync), modulo 2**(ADDR_WIDTH+1).
//    almost_full <= (level_next >= ALMOST_FULL_THRESH), same cycle as wr_level.
//  - Write while full: mem_we=0, pointer holds, overflow <= 1. Data is dropped, no other side effect.
//  - overflow: set has priority over ovf_clr in the same cycle; otherwise ovf_clr -> 0 next edge.
//  - Simultaneous write and read-pointer advance: both folded into the same next-state computation; level net change 0.
//  - No throughput limit: one write per clk while not full.
// STRUCTURE
//  - Shared package: bin2gray/gray2bin functions, FIFO ADDR_WIDTH default; reused by the read-side controller.
//  - One sub-module: gray_to_bin #(WIDTH) (combinational XOR-prefix), instantiated on rd_ptr_gray_sync.
//  - Everything else (pointer regs, flag regs, overflow) in this module.
// TESTING  (ADDR_WIDTH=4, ALMOST_FULL_THRESH=12)
//  1 Reset: assert rst_n=0 mid-stream, no clk edge -> all outputs 0 immediately; stay 0 until release.
//  2 Fill: rd_sync=0, 16 back-to-back writes -> almost_full=1 after 12th edge, full=1, wr_level=16, wr_ptr_gray=5'b11000 after 16th.
//  3 Overflow: 17th wr_en while full -> mem_we=0, wr_ptr_gray unchanged, overflow=1; ovf_clr pulse -> overflow=0; ovf_clr+bad write same cycle -> stays 1.
//  4 Release: from full, set rd_sync=5'b00001 -> next edge full=0, wr_level=15; almost_full stays 1.
//  5 Wrap: 40 writes with rd_sync tracking writes minus 2 -> every wr_ptr_gray step has Hamming distance 1; 5'b10000 -> 5'b00000 at wrap; full never set.
//  6 Concurrent: at level 15, write and rd_sync advance same edge -> wr_level=15, full=0; write alone next -> full=1.

Source files
------------

// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared FIFO definitions: default address width and Gray/binary helpers.
// The read-side controller imports the same package, so both sides share one
// Gray code definition. The helpers work on 32 bits; callers zero-extend
// narrower pointers and truncate the result. Zero upper bits do not change
// the low bits of either conversion.
package fifo_wr_ctrl_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Write-side FIFO controller bus. The master drives requests and the
// synchronized read pointer. The slave (the controller) returns the pointer,
// the address, the write enable and the flags.
import fifo_wr_ctrl_pkg::*;

interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
  logic                  wr_en;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync;
  logic [ADDR_WIDTH:0]   wr_ptr_gray;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  mem_we;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  modport master (
    output wr_en, ovf_clr, rd_ptr_gray_sync,
    input  wr_ptr_gray, wr_addr, mem_we, full, almost_full, wr_level, overflow
  );

  modport slave (
    input  wr_en, ovf_clr, rd_ptr_gray_sync,
    output wr_ptr_gray, wr_addr, mem_we, full, almost_full, wr_level, overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl_gray_to_bin.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at and above its position.
module gray_to_bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
  end
endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the asynchronous FIFO, clocked by
// the write clock. The Gray write pointer comes straight from a flop, so the
// read-domain synchronizer never samples a combinational glitch.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH         = FIFO_ADDR_WIDTH,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input logic           clk,
  input logic           rst_n,
  fifo_wr_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] r_wr_bin;
  logic [PW-1:0] r_wr_gray;
  logic [PW-1:0] r_wr_level;
  logic          r_full;
  logic          r_almost_full;
  logic          r_overflow;

  logic          w_mem_we;
  logic [PW-1:0] w_bin_next;
  logic [PW-1:0] w_gray_next;
  logic [PW-1:0] w_rd_bin;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_full_gray;

  // A write that arrives while full is dropped, so the pointer holds.
  assign w_mem_we    = bus.wr_en & ~r_full;
  assign w_bin_next  = r_wr_bin + PW'(w_mem_we);
  assign w_gray_next = PW'(bin2gray(32'(w_bin_next)));

  gray_to_bin #(.WIDTH(PW)) u_rd_g2b (
    .i_gray (bus.rd_ptr_gray_sync),
    .o_bin  (w_rd_bin)
  );

  // Level is the modulo difference of the pointers. A write and a read
  // advance in the same cycle both show up here and cancel.
  assign w_level_next = w_bin_next - w_rd_bin;

  // The FIFO is full when the write pointer is one lap ahead. In Gray code a
  // lap ahead means the top two bits are inverted and the rest are equal.
  assign w_full_gray = {~bus.rd_ptr_gray_sync[PW-1:PW-2], bus.rd_ptr_gray_sync[PW-3:0]};

  // Pointer, level and full/almost-full flags, all from the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bin      <= '0;
      r_wr_gray     <= '0;
      r_wr_level    <= '0;
      r_full        <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      r_wr_bin      <= w_bin_next;
      r_wr_gray     <= w_gray_next;
      r_wr_level    <= w_level_next;
      r_full        <= (w_gray_next == w_full_gray);
      r_almost_full <= (w_level_next >= PW'(ALMOST_FULL_THRESH));
    end
  end

  // Sticky overflow. A rejected write wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (bus.wr_en && r_full) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.wr_ptr_gray = r_wr_gray;
  assign bus.wr_addr     = r_wr_bin[ADDR_WIDTH-1:0];
  assign bus.mem_we      = w_mem_we;
  assign bus.full        = r_full;
  assign bus.almost_full = r_almost_full;
  assign bus.wr_level    = r_wr_level;
  assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed testbench for fifo_wr_ctrl (ADDR_WIDTH=4, ALMOST_FULL_THRESH=12).
// A table of vectors covers fill, overflow, release and concurrent cases.
// Hand-written sequences cover the asynchronous mid-stream reset and pointer
// wrap-around.
module tb_fifo_wr_ctrl;
  localparam int AW = 4;

  typedef struct {
    logic       wr_en;
    logic       ovf_clr;
    logic [4:0] rd_sync;
    logic       exp_we;
    logic [4:0] exp_bin;
    logic [4:0] exp_level;
    logic       exp_full;
    logic       exp_af;
    logic       exp_ovf;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];

  fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ctrl #(.ADDR_WIDTH(AW), .ALMOST_FULL_THRESH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] tb_gray(input logic [4:0] b);
    return b ^ {1'b0, b[4:1]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic we, input logic clr, input logic [4:0] rd,
                                  input logic e_we, input logic [4:0] e_bin, input logic [4:0] e_lvl,
                                  input logic e_full, input logic e_af, input logic e_ovf);
    vec_t v;
    v.wr_en = we; v.ovf_clr = clr; v.rd_sync = rd;
    v.exp_we = e_we; v.exp_bin = e_bin; v.exp_level = e_lvl;
    v.exp_full = e_full; v.exp_af = e_af; v.exp_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".gray"},  32'(bus.wr_ptr_gray), 32'd0);
    check({tag, ".addr"},  32'(bus.wr_addr),     32'd0);
    check({tag, ".full"},  32'(bus.full),        32'd0);
    check({tag, ".af"},    32'(bus.almost_full), 32'd0);
    check({tag, ".level"}, 32'(bus.wr_level),    32'd0);
    check({tag, ".ovf"},   32'(bus.overflow),    32'd0);
  endtask

  // Hard bound on simulated time so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0] prev_gray;
    logic [4:0] rd_bin;
    logic [4:0] exp_bin;
    n_checks = 0;
    n_fail   = 0;

    // Fill: 16 back-to-back writes with the read pointer at 0.
    for (int k = 1; k <= 16; k++) begin
      add_vec(1'b1, 1'b0, 5'd0, 1'b1, 5'(k), 5'(k), (k == 16), (k >= 12), 1'b0);
    end
    // Overflow: a write while full is dropped. A clear pulse resets the
    // sticky flag. A clear together with a bad write leaves it set.
    add_vec(1'b1, 1'b0, 5'd0,     1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 5'd0,     1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b1, 5'd0,     1'b0, 5'd16, 5'd16, 1'b1, 1'b1, 1'b1);
    // Release: the read pointer advances by one.
    add_vec(1'b0, 1'b1, 5'b00001, 1'b0, 5'd16, 5'd15, 1'b0, 1'b1, 1'b0);
    // Concurrent write and read advance, then a write alone refills.
    add_vec(1'b1, 1'b0, 5'b00011, 1'b1, 5'd17, 5'd15, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 5'b00011, 1'b1, 5'd18, 5'd16, 1'b1, 1'b1, 1'b0);
    add_vec(1'b1, 1'b0, 5'b00011, 1'b0, 5'd18, 5'd16, 1'b1, 1'b1, 1'b1);

    // Reset state at power-up.
    rst_n = 1'b0;
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;
    bus.rd_ptr_gray_sync = '0;
    #3;
    check_all_zero("reset");
    check("reset.mem_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors. Inputs are driven on the falling edge, mem_we is
    // sampled before the rising edge, and registered outputs just after it.
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.wr_en = vecs[i].wr_en;
      bus.ovf_clr = vecs[i].ovf_clr;
      bus.rd_ptr_gray_sync = vecs[i].rd_sync;
      #1;
      check($sformatf("v%0d.mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
      @(posedge clk);
      #1;
      check($sformatf("v%0d.gray", i),  32'(bus.wr_ptr_gray), 32'(tb_gray(vecs[i].exp_bin)));
      check($sformatf("v%0d.addr", i),  32'(bus.wr_addr),     32'(vecs[i].exp_bin[3:0]));
      check($sformatf("v%0d.level", i), 32'(bus.wr_level),    32'(vecs[i].exp_level));
      check($sformatf("v%0d.full", i),  32'(bus.full),        32'(vecs[i].exp_full));
      check($sformatf("v%0d.af", i),    32'(bus.almost_full), 32'(vecs[i].exp_af));
      check($sformatf("v%0d.ovf", i),   32'(bus.overflow),    32'(vecs[i].exp_ovf));
      $display("vec %0d: wr_en=%0b clr=%0b rd=%05b -> gray=%05b lvl=%0d full=%0b af=%0b ovf=%0b",
               i, vecs[i].wr_en, vecs[i].ovf_clr, vecs[i].rd_sync, bus.wr_ptr_gray,
               bus.wr_level, bus.full, bus.almost_full, bus.overflow);
    end
    check("pre_reset.gray_nonzero", 32'(bus.wr_ptr_gray != 5'd0), 32'd1);

    // Mid-stream asynchronous reset: outputs must clear with no clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    $display("async reset asserted mid-cycle: gray=%05b lvl=%0d full=%0b ovf=%0b",
             bus.wr_ptr_gray, bus.wr_level, bus.full, bus.overflow);
    bus.wr_en = 1'b1;
    bus.rd_ptr_gray_sync = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.ovf_clr = 1'b0;
    rst_n = 1'b1;

    // Wrap: 40 writes with the read pointer trailing the writes by two.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rd_bin = (k >= 2) ? 5'(k - 2) : 5'd0;
      exp_bin = 5'(k + 1);
      bus.wr_en = 1'b1;
      bus.rd_ptr_gray_sync = tb_gray(rd_bin);
      prev_gray = bus.wr_ptr_gray;
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d.gray", k),  32'(bus.wr_ptr_gray), 32'(tb_gray(exp_bin)));
      check($sformatf("wrap%0d.hd", k),    32'($countones(bus.wr_ptr_gray ^ prev_gray)), 32'd1);
      check($sformatf("wrap%0d.full", k),  32'(bus.full), 32'd0);
      check($sformatf("wrap%0d.level", k), 32'(bus.wr_level), 32'(5'(exp_bin - rd_bin)));
      if (k == 31) begin
        check("wrap.prev_10000", 32'(prev_gray), 32'b10000);
        check("wrap.next_00000", 32'(bus.wr_ptr_gray), 32'b00000);
      end
      $display("wrap %0d: rd=%05b gray %05b -> %05b lvl=%0d full=%0b",
               k, bus.rd_ptr_gray_sync, prev_gray, bus.wr_ptr_gray, bus.wr_level, bus.full);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
